// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO with arbitrary capacity, FWFT or registered read, count and status flags
module fifo_sync_flags #(
  parameter int p_WIDTH    = 8,
  parameter int p_CAPACITY = 16,
  parameter int p_FWFT     = 1,
  parameter int p_AFULL    = p_CAPACITY - 1,
  parameter int p_AEMPTY   = 1
) (
  input  logic                            iw_clk,
  input  logic                            iw_reset,
  input  logic                            iw_clear,
  input  logic [p_WIDTH-1:0]              iwv_wrdata,
  input  logic                            iw_wrena,
  input  logic                            iw_rdena,
  output logic [p_WIDTH-1:0]              owv_rddata,
  output logic                            ow_rdvalid,
  output logic                            ow_full,
  output logic                            ow_empty,
  output logic [$clog2(p_CAPACITY+1)-1:0] owv_count,
  output logic                            ow_almost_full,
  output logic                            ow_almost_empty,
  output logic                            ow_overflow,
  output logic                            ow_underflow
);
  localparam int CW = $clog2(p_CAPACITY + 1);
  localparam int PW = p_CAPACITY > 1 ? $clog2(p_CAPACITY) : 1;
  if (p_WIDTH < 1 || p_CAPACITY < 1 || p_AFULL > p_CAPACITY || p_AEMPTY >= p_CAPACITY) begin : g_param_err
    $error("fifo_sync_flags: illegal parameter combination");
  end
  logic [p_WIDTH-1:0] mem_q [p_CAPACITY];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [p_WIDTH-1:0] rddata_q, rddata_d;
  logic ovf_q, ovf_d, unf_q, unf_d, rdvalid_q, rdvalid_d;
  logic flush, wr_acc, rd_acc;
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return p == PW'(p_CAPACITY - 1) ? '0 : p + PW'(1);
  endfunction
  assign ow_full         = count_q == CW'(p_CAPACITY);
  assign ow_empty        = count_q == '0;
  assign ow_almost_full  = count_q >= CW'(p_AFULL);
  assign ow_almost_empty = count_q <= CW'(p_AEMPTY);
  assign owv_count       = count_q;
  assign ow_overflow     = ovf_q;
  assign ow_underflow    = unf_q;
  assign owv_rddata      = p_FWFT != 0 ? mem_q[rd_ptr_q] : rddata_q;
  assign ow_rdvalid      = p_FWFT != 0 ? ~ow_empty : rdvalid_q;
  always_comb begin
    flush     = iw_reset | iw_clear;
    wr_acc    = iw_wrena & ~ow_full & ~flush;
    rd_acc    = iw_rdena & ~ow_empty & ~flush;
    wr_ptr_d  = flush ? '0 : wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = flush ? '0 : rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d   = flush ? '0 : (wr_acc && !rd_acc) ? count_q + CW'(1) :
                (rd_acc && !wr_acc) ? count_q - CW'(1) : count_q;
    ovf_d     = ~flush & (ovf_q | (iw_wrena & ow_full));
    unf_d     = ~flush & (unf_q | (iw_rdena & ow_empty));
    rdvalid_d = rd_acc;
    rddata_d  = rd_acc ? mem_q[rd_ptr_q] : rddata_q;
  end
  // storage is never reset; only the pointers define what is valid
  always_ff @(posedge iw_clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= iwv_wrdata;
    rddata_q <= rddata_d;
  end
  always_ff @(posedge iw_clk) begin
    if (iw_reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      rdvalid_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      rdvalid_q <= rdvalid_d;
    end
  end
endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb_fifo_sync_flags: directed and randomized checks of fifo_sync_flags against a queue-based model
module tb_fifo_sync_flags;
  localparam int CAP = 5;
  logic clk = 0, reset = 1, clear = 0, wrena = 0, rdena = 0;
  logic [7:0] wrdata = 0;
  logic [7:0] a_rddata, b_rddata, c_rddata;
  logic a_rdvalid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic b_rdvalid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic c_rdvalid, c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
  logic [2:0] a_count, b_count;
  logic [4:0] c_count;
  int tests = 0, fails = 0;
  logic [7:0] q[$];
  bit m_ovf, m_unf, m_bv;
  logic [7:0] m_bd;
  always #5 clk = ~clk;
  fifo_sync_flags #(.p_WIDTH(8), .p_CAPACITY(CAP), .p_FWFT(1)) u_a (
    .iw_clk(clk), .iw_reset(reset), .iw_clear(clear), .iwv_wrdata(wrdata), .iw_wrena(wrena), .iw_rdena(rdena),
    .owv_rddata(a_rddata), .ow_rdvalid(a_rdvalid), .ow_full(a_full), .ow_empty(a_empty), .owv_count(a_count),
    .ow_almost_full(a_af), .ow_almost_empty(a_ae), .ow_overflow(a_ovf), .ow_underflow(a_unf));
  fifo_sync_flags #(.p_WIDTH(8), .p_CAPACITY(CAP), .p_FWFT(0)) u_b (
    .iw_clk(clk), .iw_reset(reset), .iw_clear(clear), .iwv_wrdata(wrdata), .iw_wrena(wrena), .iw_rdena(rdena),
    .owv_rddata(b_rddata), .ow_rdvalid(b_rdvalid), .ow_full(b_full), .ow_empty(b_empty), .owv_count(b_count),
    .ow_almost_full(b_af), .ow_almost_empty(b_ae), .ow_overflow(b_ovf), .ow_underflow(b_unf));
  fifo_sync_flags #(.p_WIDTH(8), .p_CAPACITY(16)) u_c (
    .iw_clk(clk), .iw_reset(reset), .iw_clear(clear), .iwv_wrdata(wrdata), .iw_wrena(wrena), .iw_rdena(rdena),
    .owv_rddata(c_rddata), .ow_rdvalid(c_rdvalid), .ow_full(c_full), .ow_empty(c_empty), .owv_count(c_count),
    .ow_almost_full(c_af), .ow_almost_empty(c_ae), .ow_overflow(c_ovf), .ow_underflow(c_unf));
  task automatic step();
    bit f, e;
    @(posedge clk);
    f = q.size() == CAP;
    e = q.size() == 0;
    if (reset || clear) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
      m_bv = 0;
    end else begin
      m_ovf |= wrena & f;
      m_unf |= rdena & e;
      m_bv = rdena & !e;
      if (rdena && !e) m_bd = q.pop_front();
      if (wrena && !f) q.push_back(wrdata);
    end
    #1;
  endtask
  task automatic drive(input bit w, input bit r, input logic [7:0] d);
    wrena = w;
    rdena = r;
    wrdata = d;
    step();
    wrena = 0;
    rdena = 0;
  endtask
  task automatic do_clear();
    clear = 1;
    drive(0, 0, 0);
    clear = 0;
  endtask
  task automatic test_reset();
    reset = 1;
    drive(0, 0, 0);
    drive(1, 1, 8'hEE);
    reset = 0;
    drive(0, 0, 0);
    tests++; if (c_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b exp=1", c_empty); end
    tests++; if (c_full !== 1'b0) begin fails++; $display("FAIL reset_full got=%b exp=0", c_full); end
    tests++; if (c_count !== 5'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", c_count); end
    tests++; if (c_ae !== 1'b1) begin fails++; $display("FAIL reset_aempty got=%b exp=1", c_ae); end
    tests++; if (c_af !== 1'b0) begin fails++; $display("FAIL reset_afull got=%b exp=0", c_af); end
    tests++; if ({c_ovf, c_unf} !== 2'b00) begin fails++; $display("FAIL reset_err got=%b%b exp=00", c_ovf, c_unf); end
    tests++; if ({a_rdvalid, b_rdvalid, c_rdvalid} !== 3'b000) begin fails++; $display("FAIL reset_rdvalid got=%b%b%b exp=000", a_rdvalid, b_rdvalid, c_rdvalid); end
  endtask
  task automatic test_fill_overflow();
    logic [7:0] e;
    do_clear();
    for (int i = 0; i < 5; i++) drive(1, 0, 8'(8'h11 + i));
    tests++; if ({a_full, a_af} !== 2'b11) begin fails++; $display("FAIL fill_full got=%b%b exp=11", a_full, a_af); end
    tests++; if (a_count !== 3'd5) begin fails++; $display("FAIL fill_count got=%0d exp=5", a_count); end
    tests++; if (a_ovf !== 1'b0) begin fails++; $display("FAIL fill_ovf_early got=%b exp=0", a_ovf); end
    drive(1, 0, 8'h16);
    tests++; if (a_ovf !== 1'b1 || b_ovf !== 1'b1) begin fails++; $display("FAIL ovf_set got=%b%b exp=11", a_ovf, b_ovf); end
    tests++; if (a_count !== 3'd5) begin fails++; $display("FAIL ovf_count got=%0d exp=5", a_count); end
    for (int i = 0; i < 5; i++) begin
      e = 8'(8'h11 + i);
      tests++; if (a_rddata !== e) begin fails++; $display("FAIL fwft_order[%0d] got=%h exp=%h", i, a_rddata, e); end
      drive(0, 1, 0);
      tests++; if (b_rdvalid !== 1'b1 || b_rddata !== e) begin fails++; $display("FAIL reg_order[%0d] got=%b/%h exp=1/%h", i, b_rdvalid, b_rddata, e); end
    end
    tests++; if (a_empty !== 1'b1 || a_count !== 3'd0) begin fails++; $display("FAIL drain_empty got=%b/%0d exp=1/0", a_empty, a_count); end
  endtask
  task automatic test_wrap();
    do_clear();
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 8'(i));
      tests++; if (a_count !== 3'd1 || a_rddata !== 8'(i)) begin fails++; $display("FAIL wrap_head[%0d] got=%0d/%h exp=1/%h", i, a_count, a_rddata, 8'(i)); end
      drive(0, 1, 0);
      tests++; if (b_rddata !== 8'(i) || a_count !== 3'd0) begin fails++; $display("FAIL wrap_read[%0d] got=%h/%0d exp=%h/0", i, b_rddata, a_count, 8'(i)); end
    end
  endtask
  task automatic test_simultaneous();
    do_clear();
    for (int i = 0; i < 5; i++) drive(1, 0, 8'(8'h20 + i));
    tests++; if (a_rddata !== 8'h20) begin fails++; $display("FAIL sim_full_head got=%h exp=20", a_rddata); end
    drive(1, 1, 8'h99);
    tests++; if (a_count !== 3'd4 || a_full !== 1'b0) begin fails++; $display("FAIL sim_full_count got=%0d/%b exp=4/0", a_count, a_full); end
    tests++; if (a_ovf !== 1'b1) begin fails++; $display("FAIL sim_full_ovf got=%b exp=1", a_ovf); end
    tests++; if (b_rddata !== 8'h20 || a_rddata !== 8'h21) begin fails++; $display("FAIL sim_full_data got=%h/%h exp=20/21", b_rddata, a_rddata); end
    for (int i = 1; i < 5; i++) begin
      drive(0, 1, 0);
      tests++; if (b_rddata !== 8'(8'h20 + i)) begin fails++; $display("FAIL sim_full_drain[%0d] got=%h exp=%h", i, b_rddata, 8'(8'h20 + i)); end
    end
    tests++; if (a_empty !== 1'b1) begin fails++; $display("FAIL sim_full_dropped got=%b exp=1", a_empty); end
    do_clear();
    drive(1, 1, 8'h77);
    tests++; if (a_count !== 3'd1 || a_unf !== 1'b1) begin fails++; $display("FAIL sim_empty got=%0d/%b exp=1/1", a_count, a_unf); end
    tests++; if (a_rddata !== 8'h77 || b_rdvalid !== 1'b0) begin fails++; $display("FAIL sim_empty_data got=%h/%b exp=77/0", a_rddata, b_rdvalid); end
    drive(0, 1, 0);
    tests++; if (b_rddata !== 8'h77 || b_rdvalid !== 1'b1 || a_empty !== 1'b1) begin fails++; $display("FAIL sim_empty_read got=%h/%b/%b exp=77/1/1", b_rddata, b_rdvalid, a_empty); end
  endtask
  task automatic test_regread();
    do_clear();
    drive(1, 0, 8'hA5);
    drive(0, 0, 0);
    tests++; if (b_rdvalid !== 1'b0) begin fails++; $display("FAIL regread_pre got=%b exp=0", b_rdvalid); end
    drive(0, 1, 0);
    tests++; if (b_rdvalid !== 1'b1 || b_rddata !== 8'hA5) begin fails++; $display("FAIL regread_t1 got=%b/%h exp=1/a5", b_rdvalid, b_rddata); end
    drive(0, 0, 0);
    tests++; if (b_rdvalid !== 1'b0 || b_rddata !== 8'hA5) begin fails++; $display("FAIL regread_t2 got=%b/%h exp=0/a5", b_rdvalid, b_rddata); end
  endtask
  task automatic test_clear_reset();
    for (int k = 0; k < 2; k++) begin
      do_clear();
      drive(0, 1, 0);
      for (int i = 0; i < 3; i++) drive(1, 0, 8'(8'h31 + i));
      tests++; if (a_unf !== 1'b1 || a_count !== 3'd3) begin fails++; $display("FAIL flush%0d_setup got=%b/%0d exp=1/3", k, a_unf, a_count); end
      if (k == 0) clear = 1; else reset = 1;
      drive(1, 0, 8'h3F);
      clear = 0;
      reset = 0;
      tests++; if (a_count !== 3'd0 || a_empty !== 1'b1) begin fails++; $display("FAIL flush%0d_count got=%0d/%b exp=0/1", k, a_count, a_empty); end
      tests++; if ({a_ovf, a_unf, b_rdvalid} !== 3'b000) begin fails++; $display("FAIL flush%0d_flags got=%b%b%b exp=000", k, a_ovf, a_unf, b_rdvalid); end
      drive(0, 0, 0);
      tests++; if (a_count !== 3'd0) begin fails++; $display("FAIL flush%0d_nowrite got=%0d exp=0", k, a_count); end
      drive(1, 0, 8'h55);
      tests++; if (a_rddata !== 8'h55) begin fails++; $display("FAIL flush%0d_ptr got=%h exp=55", k, a_rddata); end
    end
  endtask
  task automatic test_random();
    int sz;
    do_clear();
    for (int n = 0; n < 800; n++) begin
      clear = $urandom_range(0, 79) == 0;
      drive($urandom_range(0, 99) < ((n % 200) < 100 ? 70 : 30), $urandom_range(0, 99) < ((n % 200) < 100 ? 30 : 70), 8'($urandom));
      clear = 0;
      sz = q.size();
      tests++; if (a_count !== 3'(sz) || b_count !== 3'(sz)) begin fails++; $display("FAIL rnd_count[%0d] got=%0d/%0d exp=%0d", n, a_count, b_count, sz); end
      tests++; if ({a_full, a_empty, a_af, a_ae} !== {sz == CAP, sz == 0, sz >= CAP - 1, sz <= 1}) begin fails++; $display("FAIL rnd_flags[%0d] got=%b%b%b%b size=%0d", n, a_full, a_empty, a_af, a_ae, sz); end
      tests++; if ({a_ovf, a_unf} !== {m_ovf, m_unf}) begin fails++; $display("FAIL rnd_err[%0d] got=%b%b exp=%b%b", n, a_ovf, a_unf, m_ovf, m_unf); end
      tests++; if (a_rdvalid !== (sz != 0) || b_rdvalid !== m_bv) begin fails++; $display("FAIL rnd_rdvalid[%0d] got=%b/%b exp=%b/%b", n, a_rdvalid, b_rdvalid, sz != 0, m_bv); end
      if (sz != 0) begin
        tests++; if (a_rddata !== q[0]) begin fails++; $display("FAIL rnd_fwft[%0d] got=%h exp=%h", n, a_rddata, q[0]); end
      end
      if (m_bv) begin
        tests++; if (b_rddata !== m_bd) begin fails++; $display("FAIL rnd_reg[%0d] got=%h exp=%h", n, b_rddata, m_bd); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_fill_overflow();
    test_wrap();
    test_simultaneous();
    test_regread();
    test_clear_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
